// File: rtl/keccak_pkg.sv
// Keccak state geometry shared by the input assembler slice.
// Holds state/chunk/lane widths, tracker state type and flat lane-bit index.
package keccak_pkg;

  localparam int STATE_W = 1600;
  localparam int CHUNK_W = 200;
  localparam int NCHUNK  = 8;
  localparam int LANE_W  = 64;

  typedef enum logic {
    TRK_EMPTY,
    TRK_FILL
  } trk_state_e;

  // Flat bit of lane (x,y), bit z: 64*(5*y+x)+z.
  function automatic int flat_idx(
    input int x,
    input int y,
    input int z
  );
    return LANE_W * (5 * y + x) + z;
  endfunction

endpackage

// File: rtl/input_assembler_if.sv
// Chunk-in / state-out bundle for input_assembler.
// master: chunk producer (pushin/dix/din out); slave: the assembler.
interface input_assembler_if
  import keccak_pkg::*;
#(
  parameter int TAG_W = 8
);

  logic               pushin;
  logic [2:0]         dix;
  logic [CHUNK_W-1:0] din;
  logic [STATE_W-1:0] dout;
  logic               pushout;
  logic [TAG_W-1:0]   tagout;
  logic               dup_err;

  modport master (
    output pushin, dix, din,
    input  dout, pushout, tagout, dup_err
  );

  modport slave (
    input  pushin, dix, din,
    output dout, pushout, tagout, dup_err
  );

endinterface

// File: rtl/chunk_tracker.sv
// Tracks which of the 8 chunks of the current block have arrived.
// Ports: clk, reset (async low), pushin, dix -> complete (comb), dup (opt).
module chunk_tracker
  import keccak_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       pushin,
  input  logic [2:0] dix,
  output logic       complete
`ifdef IA_DUP_ERR_EN
  ,
  output logic       dup
`endif
);

  logic [NCHUNK-1:0] valid_q, valid_d;
  logic [NCHUNK-1:0] hit;
  logic              seen;
  trk_state_e        state_q, state_d;

  always_comb begin
    hit      = '0;
    hit[dix] = 1'b1;
    seen     = |(valid_q & hit);
    // A repeated index never completes: it only overwrites the slot.
    complete = pushin && !seen && ((valid_q | hit) == '1);
    valid_d  = valid_q;
    state_d  = state_q;
    unique case (1'b1)
      complete: begin
        valid_d = '0;
        state_d = TRK_EMPTY;
      end
      (pushin && !complete): begin
        valid_d = valid_q | hit;
        state_d = TRK_FILL;
      end
      default: ;
    endcase
  end

`ifdef IA_DUP_ERR_EN
  assign dup = pushin && seen;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      state_q <= TRK_EMPTY;
    end else begin
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/input_assembler.sv
// Assembles eight 200-bit chunks into a 1600-bit Keccak state plus tag.
// Ports: clk, reset, pushin/dix/din in; dout/pushout/tagout out; IA_DUP_ERR_EN adds dup_err.
module input_assembler
  import keccak_pkg::*;
#(
  parameter int TAG_W = 8
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               pushin,
  input  logic [2:0]         dix,
  input  logic [CHUNK_W-1:0] din,
  output logic [STATE_W-1:0] dout,
  output logic               pushout,
  output logic [TAG_W-1:0]   tagout
`ifdef IA_DUP_ERR_EN
  ,
  output logic               dup_err
`endif
);

  logic [NCHUNK-1:0][CHUNK_W-1:0] asm_q, asm_d, merged;
  logic [STATE_W-1:0]             dout_q, dout_d;
  logic                           pushout_q, pushout_d;
  logic [TAG_W-1:0]               tagout_q, tagout_d;
  logic [TAG_W-1:0]               cnt_q, cnt_d;
  logic                           complete;

`ifdef IA_DUP_ERR_EN
  logic dup;
  logic dup_err_q, dup_err_d;
`endif

  chunk_tracker u_trk (
    .clk      (clk),
    .reset    (reset),
    .pushin   (pushin),
    .dix      (dix),
    .complete (complete)
`ifdef IA_DUP_ERR_EN
    ,
    .dup      (dup)
`endif
  );

  always_comb begin
    // Completing chunk goes straight into dout alongside the held ones.
    merged      = asm_q;
    merged[dix] = din;
    asm_d       = pushin ? merged : asm_q;
    dout_d      = complete ? merged : dout_q;
    pushout_d   = complete;
    tagout_d    = complete ? cnt_q : tagout_q;
    cnt_d       = complete ? cnt_q + 1'b1 : cnt_q;
`ifdef IA_DUP_ERR_EN
    dup_err_d   = dup_err_q | dup;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      asm_q     <= '0;
      dout_q    <= '0;
      pushout_q <= 1'b0;
      tagout_q  <= '0;
      cnt_q     <= '0;
`ifdef IA_DUP_ERR_EN
      dup_err_q <= 1'b0;
`endif
    end else begin
      asm_q     <= asm_d;
      dout_q    <= dout_d;
      pushout_q <= pushout_d;
      tagout_q  <= tagout_d;
      cnt_q     <= cnt_d;
`ifdef IA_DUP_ERR_EN
      dup_err_q <= dup_err_d;
`endif
    end
  end

  assign dout    = dout_q;
  assign pushout = pushout_q;
  assign tagout  = tagout_q;
`ifdef IA_DUP_ERR_EN
  assign dup_err = dup_err_q;
`endif

endmodule

// File: tb/tb_input_assembler.sv
// Bench for input_assembler: random chunks vs a block-level model.
// Runs TAG_W=8 and TAG_W=2 instances on the same stimulus.
module tb_input_assembler;
  import keccak_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  input_assembler_if #(.TAG_W(8)) ia ();
  input_assembler_if #(.TAG_W(2)) ib ();

  assign ib.pushin = ia.pushin;
  assign ib.dix    = ia.dix;
  assign ib.din    = ia.din;

  input_assembler #(.TAG_W(8)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .pushin  (ia.pushin),
    .dix     (ia.dix),
    .din     (ia.din),
    .dout    (ia.dout),
    .pushout (ia.pushout),
    .tagout  (ia.tagout)
`ifdef IA_DUP_ERR_EN
    ,
    .dup_err (ia.dup_err)
`endif
  );

  input_assembler #(.TAG_W(2)) dut2 (
    .clk     (clk),
    .reset   (rst_n),
    .pushin  (ib.pushin),
    .dix     (ib.dix),
    .din     (ib.din),
    .dout    (ib.dout),
    .pushout (ib.pushout),
    .tagout  (ib.tagout)
`ifdef IA_DUP_ERR_EN
    ,
    .dup_err (ib.dup_err)
`endif
  );

  int errs = 0;
  int checks = 0;
  int npo = 0;

  // Block-level reference: slots, arrival set, emitted state and count.
  logic [CHUNK_W-1:0] slot [NCHUNK];
  bit   [NCHUNK-1:0]  have;
  logic [STATE_W-1:0] exp_dout;
  bit                 exp_po;
  int                 blocks;
  int                 exp_tag;
  bit                 exp_dup;

  task automatic chk(string tag, logic [199:0] got, logic [199:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CHUNK_W-1:0] rnd200();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[32*i +: 32] = $urandom;
    return r[CHUNK_W-1:0];
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      have = '0; exp_dout = '0; exp_po = 0;
      exp_tag = 0; blocks = 0; exp_dup = 0;
      for (int k = 0; k < NCHUNK; k++) slot[k] = '0;
    end else begin
      exp_po = 0;
      if (ia.pushin) begin
        slot[ia.dix] = ia.din;
        if (have[ia.dix]) exp_dup = 1;
        else have[ia.dix] = 1;
        if (have == 8'hFF) begin
          for (int k = 0; k < NCHUNK; k++)
            exp_dout[CHUNK_W*k +: CHUNK_W] = slot[k];
          exp_po = 1;
          exp_tag = blocks;
          blocks++;
          have = '0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("pushout", 200'(ia.pushout), 200'(exp_po));
    chk("tagout", 200'(ia.tagout), 200'(exp_tag % 256));
    chk("pushout_w2", 200'(ib.pushout), 200'(exp_po));
    chk("tagout_w2", 200'(ib.tagout), 200'(exp_tag % 4));
    for (int k = 0; k < NCHUNK; k++)
      chk($sformatf("dout%0d", k), ia.dout[CHUNK_W*k +: CHUNK_W],
          exp_dout[CHUNK_W*k +: CHUNK_W]);
`ifdef IA_DUP_ERR_EN
    chk("dup_err", 200'(ia.dup_err), 200'(exp_dup));
`endif
    if (ia.pushout === 1'b1) npo++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    compare_all();
    @(negedge clk);
  endtask

  task automatic push(input int d, input logic [CHUNK_W-1:0] v);
    ia.pushin = 1'b1;
    ia.dix = 3'(d);
    ia.din = v;
    tick();
    ia.pushin = 1'b0;
  endtask

  task automatic idle(input int n);
    ia.pushin = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic shuffle(output int ord [8]);
    int t, j;
    for (int i = 0; i < 8; i++) ord[i] = i;
    for (int i = 7; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
  endtask

  initial begin
    int ord [8];
    int p0;
    logic [CHUNK_W-1:0] va, vb;
    int seq [8];

    ia.pushin = 1'b0; ia.dix = '0; ia.din = '0;
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Sequential chunks, din = k+1.
    for (int k = 0; k < 8; k++) push(k, CHUNK_W'(k + 1));
    chk("seq_po", 200'(ia.pushout), 200'd1);
    for (int k = 0; k < 8; k++)
      chk("seq_chunk", ia.dout[CHUNK_W*k +: CHUNK_W], CHUNK_W'(k + 1));
    chk("seq_tag", 200'(ia.tagout), 200'd0);
    idle(2);

    // Scrambled order with short gaps.
    seq = '{7, 3, 0, 5, 1, 6, 2, 4};
    p0 = npo;
    for (int i = 0; i < 8; i++) begin
      push(seq[i], rnd200());
      idle($urandom_range(3, 0));
    end
    idle(1);
    chk("gap_one_po", 200'(npo - p0), 200'd1);

    // Repeated dix 2: last write wins, one completion.
    va = rnd200(); vb = rnd200();
    p0 = npo;
    push(2, va);
    push(0, rnd200()); push(1, rnd200());
    push(2, vb);
    for (int k = 3; k < 8; k++) push(k, rnd200());
    idle(1);
    chk("dup_one_po", 200'(npo - p0), 200'd1);
    chk("dup_chunk2", ia.dout[CHUNK_W*2 +: CHUNK_W], vb);

    // 16 back-to-back blocks, shuffled order, no idles.
    p0 = npo;
    for (int b = 0; b < 16; b++) begin
      shuffle(ord);
      for (int i = 0; i < 8; i++) push(ord[i], rnd200());
    end
    idle(1);
    chk("b2b_16_po", 200'(npo - p0), 200'd16);

    // Random traffic with occasional repeats and idles.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3, 0) == 0) idle(1);
      else push($urandom_range(7, 0), rnd200());
    end

    // Partial block then reset; pushin held during reset is ignored.
    idle(1);
    for (int k = 0; k < 5; k++) push(k, rnd200());
    rst_n = 1'b0;
    ia.pushin = 1'b1;
    ia.dix = 3'd5;
    ia.din = rnd200();
    tick();
    tick();
    chk("rst_po", 200'(ia.pushout), 200'd0);
    chk("rst_tag", 200'(ia.tagout), 200'd0);
    chk("rst_dout0", ia.dout[CHUNK_W-1:0], '0);
    ia.pushin = 1'b0;
    rst_n = 1'b1;
    idle(1);
    p0 = npo;
    for (int k = 7; k >= 0; k--) push(k, rnd200());
    chk("rst_tag0", 200'(ia.tagout), 200'd0);
    idle(2);
    chk("rst_one_po", 200'(npo - p0), 200'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
